// File: rtl/mdsa_pkg.sv
// Shared constants, state encoding and element type for the MDSA shearsort core.
// Optional feature macro: MDSA_INDEX_OUT_EN (each element also carries its load position).
package mdsa_pkg;

   localparam int N      = 3;                 // matrix dimension
   localparam int W      = 8;                 // element width
   localparam int NN     = N * N;             // elements per job
   localparam int IW     = $clog2(NN);        // load-position / element-counter width
   localparam int RC_W   = $clog2(N);         // row, column and step width
   localparam int R      = $clog2(N) + 1;     // ROW,COL pair repetitions
   localparam int PHASES = 2 * R + 1;         // pairs plus one closing ROW phase
   localparam int PH_W   = $clog2(PHASES);

   typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_e;

   typedef struct packed {
      logic [W-1:0]  data;
`ifdef MDSA_INDEX_OUT_EN
      logic [IW-1:0] idx;
`endif
   } elem_t;

endpackage

// File: rtl/mdsa_if.sv
// Job/data stream interface of the MDSA core. With MDSA_INDEX_OUT_EN the output side
// also carries the original load position of every streamed element.
interface mdsa_if;
   import mdsa_pkg::*;

   logic          start;
   logic          en;
   logic [W-1:0]  data_in;
   logic          rdy;
   logic          output_enable;
   logic [W-1:0]  data_out;
`ifdef MDSA_INDEX_OUT_EN
   logic [IW-1:0] data_idx;
`endif

   modport slave (
      input  start, en, data_in,
      output rdy, output_enable,
`ifdef MDSA_INDEX_OUT_EN
      output data_idx,
`endif
      output data_out
   );

   modport master (
      output start, en, data_in,
      input  rdy, output_enable,
`ifdef MDSA_INDEX_OUT_EN
      input  data_idx,
`endif
      input  data_out
   );

endinterface

// File: rtl/mdsa_cas.sv
// Combinational compare-and-swap of two elements. first_o receives the smaller value
// when ascending (desc_i=0) and the larger when descending; equal values never swap.
module mdsa_cas
   import mdsa_pkg::*;
(
   input  elem_t a_i,
   input  elem_t b_i,
   input  logic  desc_i,
   output elem_t first_o,
   output elem_t second_o
);

   logic swap;

   assign swap     = desc_i ? (a_i.data < b_i.data) : (a_i.data > b_i.data);
   assign first_o  = swap ? b_i : a_i;
   assign second_o = swap ? a_i : b_i;

endmodule

// File: rtl/mdsa_top.sv
// MDSA top: serial load into an NxN register matrix, shearsort with odd-even
// transposition row/column phases, serial snake-order (ascending) output.
// Optional feature macro: MDSA_INDEX_OUT_EN adds bus.data_idx.
module mdsa_top
   import mdsa_pkg::*;
(
   input logic   clk,
   input logic   rst,
   mdsa_if.slave bus
);

   state_e          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;      // load position in LOAD, output position in OUT
   logic [RC_W-1:0] step_q, step_d;
   logic [PH_W-1:0] phase_q, phase_d;
   elem_t           mat_q [N][N];
   elem_t           mat_d [N][N];
   elem_t           out_q, out_d;
   logic            oe_q, oe_d;

   elem_t           row_lo [N][N-1];
   elem_t           row_hi [N][N-1];
   elem_t           col_lo [N][N-1];
   elem_t           col_hi [N][N-1];

   logic [RC_W-1:0] cur_row, cur_col, snake_col;
   logic            last_elem, last_step, last_phase;
   elem_t           load_elem;

   assign cur_row    = RC_W'(int'(cnt_q) / N);
   assign cur_col    = RC_W'(int'(cnt_q) % N);
   assign snake_col  = cur_row[0] ? (RC_W'(N - 1) - cur_col) : cur_col;
   assign last_elem  = (cnt_q == IW'(NN - 1));
   assign last_step  = (step_q == RC_W'(N - 1));
   assign last_phase = (phase_q == PH_W'(PHASES - 1));

   // Tag the incoming word with its load position when index tracking is built in.
   always_comb begin
      load_elem      = '0;
      load_elem.data = bus.data_in;
`ifdef MDSA_INDEX_OUT_EN
      load_elem.idx  = cnt_q;
`endif
   end

   // One row network (odd rows descending) and one column network, all pairs precomputed.
   for (genvar a = 0; a < N; a++) begin : g_line
      for (genvar i = 0; i < N - 1; i++) begin : g_pair
         mdsa_cas u_row_cas (
            .a_i      (mat_q[a][i]),
            .b_i      (mat_q[a][i+1]),
            .desc_i   ((a % 2) == 1),
            .first_o  (row_lo[a][i]),
            .second_o (row_hi[a][i])
         );
         mdsa_cas u_col_cas (
            .a_i      (mat_q[i][a]),
            .b_i      (mat_q[i+1][a]),
            .desc_i   (1'b0),
            .first_o  (col_lo[a][i]),
            .second_o (col_hi[a][i])
         );
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start)             state_d = LOAD;
         LOAD:    if (bus.en && last_elem)   state_d = SORT;
         SORT:    if (last_phase && last_step) state_d = OUT;
         OUT:     if (last_elem)             state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: load writes, parallel compare-and-swap steps, output stream.
   always_comb begin
      cnt_d   = cnt_q;
      step_d  = step_q;
      phase_d = phase_q;
      mat_d   = mat_q;
      out_d   = '0;
      oe_d    = 1'b0;
      case (state_q)
         LOAD: begin
            if (bus.en) begin
               mat_d[cur_row][cur_col] = load_elem;
               cnt_d = last_elem ? '0 : cnt_q + IW'(1);
            end
         end
         SORT: begin
            for (int a = 0; a < N; a++) begin
               for (int i = 0; i < N - 1; i++) begin
                  if ((i % 2) == int'(step_q[0])) begin
                     if (!phase_q[0]) begin
                        mat_d[a][i]   = row_lo[a][i];
                        mat_d[a][i+1] = row_hi[a][i];
                     end else begin
                        mat_d[i][a]   = col_lo[a][i];
                        mat_d[i+1][a] = col_hi[a][i];
                     end
                  end
               end
            end
            step_d = last_step ? '0 : step_q + RC_W'(1);
            if (last_step) phase_d = last_phase ? '0 : phase_q + PH_W'(1);
         end
         OUT: begin
            oe_d  = 1'b1;
            out_d = mat_q[cur_row][snake_col];
            cnt_d = last_elem ? '0 : cnt_q + IW'(1);
         end
         default: cnt_d = '0;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         step_q  <= '0;
         phase_q <= '0;
         out_q   <= '0;
         oe_q    <= 1'b0;
         // NOTE: the matrix is reset too, so an aborted job leaves no stale data behind.
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               mat_q[a][b] <= '0;
      end else begin
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         mat_q   <= mat_d;
      end
   end

   assign bus.rdy           = (state_q == IDLE);
   assign bus.output_enable = oe_q;
   assign bus.data_out      = out_q.data;
`ifdef MDSA_INDEX_OUT_EN
   assign bus.data_idx      = out_q.idx;
`endif

endmodule

// File: tb/tb_mdsa_top.sv
// Self-checking bench for mdsa_top: table-driven jobs, random jobs against a sorted-queue
// reference, start pokes during SORT/OUT, and an asynchronous abort in the middle of SORT.
module tb_mdsa_top;
   import mdsa_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   mdsa_if bus ();

   mdsa_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    vals[NN];
      bit    gaps;
      bit    poke;
      string tag;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Runs one complete job from IDLE; called and returning on a falling edge.
   task automatic do_job(input vec_t v);
      int q[$];
      int k, j, waited, load_cyc;
      bit ph;
      q = {};
      for (int i = 0; i < NN; i++) q.push_back(v.vals[i]);
      q.sort();

      waited = 0;
      while (bus.rdy !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check({v.tag, "_rdy_before"}, int'(bus.rdy), 1);

      bus.start = 1'b1;
      @(negedge clk);
      k = 0; j = 0; ph = 1'b0;
      while (k < NN) begin
         bus.start = (j < 2);
         if (v.gaps && ph) begin
            bus.en      = 1'b0;
            bus.data_in = 8'hAA;
         end else begin
            bus.en      = 1'b1;
            bus.data_in = W'(v.vals[k]);
            k++;
         end
         ph = ~ph;
         j++;
         @(negedge clk);
      end
      bus.en    = 1'b0;
      bus.start = 1'b0;
      load_cyc  = cyc;
      check({v.tag, "_rdy_in_sort"}, int'(bus.rdy), 0);

      waited = 0;
      while (bus.output_enable !== 1'b1 && waited < 200) begin
         if (v.poke) bus.start = 1'b1;
         @(negedge clk);
         waited++;
      end
      if (bus.output_enable !== 1'b1) begin
         check({v.tag, "_oe_timeout"}, int'(bus.output_enable), 1);
         bus.start = 1'b0;
         return;
      end
      if (!v.gaps) check({v.tag, "_latency"}, cyc - load_cyc, 22);

      for (int i = 0; i < NN; i++) begin
         check({v.tag, "_oe"}, int'(bus.output_enable), 1);
         check({v.tag, "_data"}, int'(bus.data_out), q[i]);
`ifdef MDSA_INDEX_OUT_EN
         check({v.tag, "_idx"}, v.vals[int'(bus.data_idx)], int'(bus.data_out));
`endif
         bus.start = v.poke && (i < NN - 1);
         @(negedge clk);
      end
      bus.start = 1'b0;
      check({v.tag, "_oe_end"}, int'(bus.output_enable), 0);
      check({v.tag, "_data_end"}, int'(bus.data_out), 0);
      check({v.tag, "_rdy_end"}, int'(bus.rdy), 1);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d errors", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      int   oe_seen;

      tbl[0].vals = '{9, 8, 7, 6, 5, 4, 3, 2, 1};          tbl[0].gaps = 0; tbl[0].poke = 0; tbl[0].tag = "reverse";
      tbl[1].vals = '{5, 5, 5, 1, 1, 1, 3, 3, 3};          tbl[1].gaps = 0; tbl[1].poke = 0; tbl[1].tag = "dups";
      tbl[2].vals = '{0, 1, 2, 3, 4, 5, 6, 7, 8};          tbl[2].gaps = 0; tbl[2].poke = 0; tbl[2].tag = "sorted";
      tbl[3].vals = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
                                                           tbl[3].gaps = 0; tbl[3].poke = 0; tbl[3].tag = "all255";
      tbl[4].vals = '{9, 8, 7, 6, 5, 4, 3, 2, 1};          tbl[4].gaps = 1; tbl[4].poke = 0; tbl[4].tag = "en_gaps";
      tbl[5].vals = '{200, 3, 77, 0, 255, 14, 14, 91, 6};  tbl[5].gaps = 0; tbl[5].poke = 1; tbl[5].tag = "start_poke";

      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.en      = 1'b0;
      bus.data_in = '0;
      repeat (2) @(negedge clk);
      check("reset_rdy", int'(bus.rdy), 1);
      check("reset_oe", int'(bus.output_enable), 0);
      check("reset_data", int'(bus.data_out), 0);
      rst = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 6; t++) do_job(tbl[t]);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NN; i++) rv.vals[i] = int'($urandom_range(0, 255));
         rv.gaps = 1'($urandom_range(0, 1));
         rv.poke = 1'($urandom_range(0, 1));
         rv.tag  = "random";
         do_job(rv);
      end

      // Abort in the middle of SORT, then confirm nothing leaks out and the next job is clean.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < NN; i++) begin
         bus.en      = 1'b1;
         bus.data_in = W'(20 + i);
         @(negedge clk);
      end
      bus.en = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_rdy_in_sort", int'(bus.rdy), 0);
      rst = 1'b0;
      #1;
      check("abort_rdy", int'(bus.rdy), 1);
      check("abort_oe", int'(bus.output_enable), 0);
      check("abort_data", int'(bus.data_out), 0);
      @(negedge clk);
      rst = 1'b1;
      oe_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.output_enable === 1'b1) oe_seen++;
      end
      check("abort_no_output", oe_seen, 0);
      tbl[0].tag = "after_abort";
      do_job(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
